// File: rtl/cache_ctrl.sv
// Sequencing controller for a single-line, 512-bit-block write-back cache.
// Optional hit/miss statistics are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [31:0]       cache_wdata_word,
  output logic [LINE_W-1:0] cache_wdata_block,
  output logic              cache_we_word,
  output logic              cache_we_block,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic [ADDR_W-1:0] cache_addout,
  input  logic [31:0]       cache_rdata_word,
  input  logic [LINE_W-1:0] cache_rdata_block,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;

  logic w_busy;
  logic w_hit;
  logic w_expire;

  assign w_busy   = (r_state == WRITEBACK) || (r_state == ALLOCATE);
  assign w_hit    = (r_state == COMPARE) && cache_hit;
  // mem_ack arriving in the expiry cycle takes priority over the timeout
  assign w_expire = (TIMEOUT != 0) && w_busy && !mem_ack &&
                    (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (cache_hit) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= '0;
            r_state <= cache_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            r_cnt   <= '0;
            r_state <= ALLOCATE;
          end else if (w_expire) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            r_state <= COMPARE;
          end else if (w_expire) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // CPU / cache / memory strobes decoded from the current state
  assign cpu_ready         = w_hit || w_expire;
  assign cpu_err           = w_expire;
  assign cpu_rdata         = (w_hit && !r_we) ? cache_rdata_word : '0;
  assign cache_addr        = r_addr;
  assign cache_wdata_word  = r_wdata;
  assign cache_we_word     = w_hit && r_we;
  assign cache_we_block    = (r_state == ALLOCATE) && mem_ack;
  assign cache_wdata_block = (r_state == ALLOCATE) ? mem_rdata : '0;
  assign mem_req           = w_busy;
  assign mem_we            = (r_state == WRITEBACK);
  assign mem_wdata         = (r_state == WRITEBACK) ? cache_rdata_block : '0;

  always_comb begin
    mem_addr = '0;
    if (r_state == WRITEBACK)
      mem_addr = cache_addout;
    else if (r_state == ALLOCATE)
      mem_addr = {r_addr[ADDR_W-1:6], 6'b0};
  end

`ifdef CACHE_CTRL_STATS_EN
  logic              r_first;
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  // r_first separates the initial lookup from the post-refill re-compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && cpu_req)
        r_first <= 1'b1;
      else if (r_state == ALLOCATE && mem_ack)
        r_first <= 1'b0;
      if (w_hit && r_first && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if ((r_state == COMPARE) && !cache_hit && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural single-line cache,
// a block memory responder and a response scoreboard.
module tb_cache_ctrl;

`ifdef CACHE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_err;
  logic [31:0]  cache_addr;
  logic [31:0]  cache_wdata_word;
  logic [511:0] cache_wdata_block;
  logic         cache_we_word;
  logic         cache_we_block;
  logic         cache_hit;
  logic         cache_dirty;
  logic [31:0]  cache_addout;
  logic [31:0]  cache_rdata_word;
  logic [511:0] cache_rdata_block;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  cache_ctrl #(.ADDR_W(32), .LINE_W(512), .TIMEOUT(8), .STAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cache_addr(cache_addr), .cache_wdata_word(cache_wdata_word),
    .cache_wdata_block(cache_wdata_block), .cache_we_word(cache_we_word),
    .cache_we_block(cache_we_block), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
    .cache_addout(cache_addout), .cache_rdata_word(cache_rdata_word),
    .cache_rdata_block(cache_rdata_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } exp_t;
  exp_t sb[$];

  // single-line cache model
  logic         c_valid = 1'b0;
  logic         c_dirty = 1'b0;
  logic [25:0]  c_tag = '0;
  logic [511:0] c_line = '0;
  int           blk_we_cnt = 0;
  int           word_we_cnt = 0;
  bit           both_seen = 1'b0;

  assign cache_hit         = c_valid && (c_tag == cache_addr[31:6]);
  assign cache_dirty       = c_valid && c_dirty;
  assign cache_addout      = {c_tag, 6'b0};
  assign cache_rdata_block = c_line;
  assign cache_rdata_word  = c_line[cache_addr[5:2]*32 +: 32];

  always @(posedge clk) begin
    if (cache_we_block && cache_we_word) both_seen <= 1'b1;
    if (cache_we_block) begin
      c_line     <= cache_wdata_block;
      c_tag      <= cache_addr[31:6];
      c_valid    <= 1'b1;
      c_dirty    <= 1'b0;
      blk_we_cnt <= blk_we_cnt + 1;
    end else if (cache_we_word) begin
      c_line[cache_addr[5:2]*32 +: 32] <= cache_wdata_word;
      c_dirty     <= 1'b1;
      word_we_cnt <= word_we_cnt + 1;
    end
  end

  // block memory: unwritten blocks hold a fixed address-derived pattern
  logic [511:0] mem_q [logic [31:0]];
  int           ack_delay = 3;
  logic [31:0]  wb_addr = '0;
  logic [511:0] wb_data = '0;
  logic [31:0]  rd_addr = '0;

  function automatic logic [511:0] dflt(input logic [31:0] a);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = a ^ 32'hC0DE_0000 ^ 32'(i);
    return l;
  endfunction

  function automatic logic [511:0] get_blk(input logic [31:0] a);
    if (mem_q.exists(a)) return mem_q[a];
    return dflt(a);
  endfunction

  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        wcnt++;
        if (ack_delay != 0 && wcnt == ack_delay) begin
          mem_ack = 1'b1;
          wcnt = 0;
          if (mem_we) begin
            mem_q[mem_addr] = mem_wdata;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
          end else begin
            mem_rdata = get_blk(mem_addr);
            rd_addr = mem_addr;
          end
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata_exp, input logic err_exp,
                            input int lat_exp, input string tag);
    exp_t e;
    int   lat;
    bit   got;
    e.rdata = rdata_exp;
    e.err   = err_exp;
    e.we    = we;
    sb.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (cpu_ready) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({tag, "_err"}, cpu_err, e.err);
        if (!e.we && !e.err) chk({tag, "_rdata"}, cpu_rdata, e.rdata);
        chk({tag, "_lat"}, lat, lat_exp);
      end
    end
    cpu_req = 1'b0;
    chk({tag, "_ready_seen"}, got, 1'b1);
    if (!got) void'(sb.pop_front());
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [511:0] l40;
    logic [511:0] l40_dirty;
    logic [511:0] l2000;
    int           blk_before;
    bit           found;

    l40 = dflt(32'h40);
    l40[63:32] = 32'hDEADBEEF;
    mem_q[32'h40] = l40;
    l40_dirty = l40;
    l40_dirty[95:64] = 32'h12345678;
    l2000 = dflt(32'h2000);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_we_word", cache_we_word, 1'b0);
    chk("rst_we_block", cache_we_block, 1'b0);
    chk("rst_cache_addr", cache_addr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // cold miss and refill
    ack_delay = 3;
    cpu_access(1'b0, 32'h40, 32'h0, l40[31:0], 1'b0, 5, "cold_rd40");
    chk("cold_fetch_addr", rd_addr, 32'h40);
    chk("cold_blk_we", blk_we_cnt, 1);

    // hits, then back-to-back write and read
    cpu_access(1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 1'b0, 1, "hit_rd44");
    cpu_access(1'b1, 32'h48, 32'h12345678, 32'h0, 1'b0, 1, "hit_wr48");
    cpu_access(1'b0, 32'h48, 32'h0, 32'h12345678, 1'b0, 1, "hit_rd48");
    chk("dirty_after_write", cache_dirty, 1'b1);
    chk("word_we_pulses", word_we_cnt, 1);

    // dirty miss: write-back then refill
    cpu_access(1'b0, 32'h1000, 32'h0, dflt(32'h1000) & 512'hFFFF_FFFF, 1'b0, 8, "wb_rd1000");
    chk("wb_addr", wb_addr, 32'h40);
    chk("wb_data", wb_data, l40_dirty);
    chk("wb_fetch_addr", rd_addr, 32'h1000);

    // timeout with no ack: error, no cache write
    ack_delay = 0;
    blk_before = blk_we_cnt;
    cpu_access(1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 9, "tmo_rd2000");
    @(negedge clk);
    #1;
    chk("tmo_no_blk_we", blk_we_cnt, blk_before);
    chk("tmo_tag_kept", c_tag, 26'(32'h1000 >> 6));
    chk("tmo_mem_req_drop", mem_req, 1'b0);

    // ack in the expiry cycle wins
    ack_delay = 8;
    cpu_access(1'b0, 32'h2000, 32'h0, l2000[31:0], 1'b0, 10, "tmo_ack_rd2000");
    chk("stats_hit", hit_cnt, STATS ? 16'd3 : 16'd0);
    chk("stats_miss", miss_cnt, STATS ? 16'd4 : 16'd0);

    // reset while refilling
    ack_delay = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) found = 1'b1;
    end
    chk("mr_alloc_seen", found, 1'b1);
    chk("mr_alloc_addr", mem_addr, 32'h3000);
    chk("mr_alloc_we", mem_we, 1'b0);
    blk_before = blk_we_cnt;
    rst = 1'b0;
    #1;
    chk("mr_mem_req", mem_req, 1'b0);
    chk("mr_ready", cpu_ready, 1'b0);
    chk("mr_we_block", cache_we_block, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_idle_addr", cache_addr, 32'h0);
    chk("mr_idle_mem_req", mem_req, 1'b0);
    chk("mr_no_blk_we", blk_we_cnt, blk_before);
    chk("mr_stats_hit", hit_cnt, 16'd0);

    cpu_access(1'b0, 32'h2004, 32'h0, l2000[63:32], 1'b0, 1, "post_rst_rd2004");
    chk("post_stats_hit", hit_cnt, STATS ? 16'd1 : 16'd0);
    chk("post_stats_miss", miss_cnt, 16'd0);
    chk("we_exclusive", both_seen, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the single-line, 512-bit-block write-back cache.
- Accepts word read/write requests from the CPU side and drives the cache's address, block-write and word-write controls.
- Runs write-back and refill transfers to a block-wide memory port on miss.
- Sits between the pipeline MEM stage and the cache/main-memory pair.

Parameters:
ADDR_W, 32, byte address width; the cache tag is ADDR_W-1:6.
LINE_W, 512, block width in bits (16 words).
TIMEOUT, 0, max cycles waiting for mem_ack per transfer; 0 = wait forever.
STAT_W, 16, width of hit/miss counters (optional feature only).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
cpu_req  in  1  request; held high until cpu_ready
cpu_we  in  1  1 = word write, 0 = word read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  32  write word
cpu_rdata  out  32  read word; valid while cpu_ready && !cpu_we
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse with cpu_ready on memory timeout
cache_addr  out  ADDR_W  to cache memory_address (latched request address)
cache_wdata_word  out  32  to cache write_data_word
cache_wdata_block  out  LINE_W  to cache write_data_block (= mem_rdata)
cache_we_word  out  1  to cache we_word
cache_we_block  out  1  to cache we_block
cache_hit  in  1  from cache hit
cache_dirty  in  1  from cache dirty
cache_addout  in  ADDR_W  from cache addout (victim block address)
cache_rdata_word  in  32  from cache read_data_word
cache_rdata_block  in  LINE_W  from cache read_data_block
mem_req  out  1  memory transfer request, held until mem_ack
mem_we  out  1  1 = block write-back, 0 = block fetch
mem_addr  out  ADDR_W  block-aligned address, bits 5:0 = 0
mem_wdata  out  LINE_W  write-back data (= cache_rdata_block)
mem_rdata  in  LINE_W  fetched block
mem_ack  in  1  one-cycle transfer completion
hit_cnt  out  STAT_W  hit counter (optional feature)
miss_cnt  out  STAT_W  miss counter (optional feature)

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Reset state is IDLE.
- Reset values: all outputs 0; latched addr/we/wdata 0; timeout counter 0.
- Reset mid-transfer returns to IDLE immediately (async) and drops mem_req; no cache write occurs.
- IDLE:
  - If cpu_req, latch cpu_addr/cpu_we/cpu_wdata and go to COMPARE.
  - cache_addr always shows the latched address.
- COMPARE:
  - On cache_hit: assert cpu_ready (combinational). If latched we, also assert cache_we_word for this cycle. Go to IDLE.
  - Hit latency: cpu_ready in the cycle after acceptance.
  - On miss with cache_dirty: go to WRITEBACK. On miss and clean: go to ALLOCATE.
- WRITEBACK:
  - Drive mem_req=1, mem_we=1, mem_addr=cache_addout, mem_wdata=cache_rdata_block.
  - On mem_ack go to ALLOCATE.
- ALLOCATE:
  - Drive mem_req=1, mem_we=0, mem_addr={latched addr[ADDR_W-1:6], 6'b0}.
  - On mem_ack, assert cache_we_block that cycle (cache_wdata_block = mem_rdata), then go to COMPARE.
  - The retry in COMPARE hits; a write then lands via cache_we_word.
- mem_ack in IDLE/COMPARE is ignored.
- cpu_req while busy is ignored; the requester holds it.
- Back-to-back requests:
  - A new cpu_req is sampled in the IDLE cycle following cpu_ready.
  - Minimum period is 2 cycles per hit.
- Timeout (TIMEOUT>0):
  - Counter clears on entering WRITEBACK/ALLOCATE and increments each waiting cycle.
  - When the count reaches TIMEOUT-1 without mem_ack: pulse cpu_ready and cpu_err, drop mem_req, go to IDLE, no cache write.
  - mem_ack in the same cycle as expiry wins; no error.
- cache_we_word and cache_we_block are never asserted in the same cycle.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- Defined:
  - hit_cnt increments on each COMPARE exit via hit on first lookup.
  - Post-refill re-compares do not count as hits.
  - miss_cnt increments on each COMPARE->WRITEBACK/ALLOCATE transition.
  - Both counters saturate at all-ones, reset to 0, and the ports are live.
- Undefined: counter registers are absent; hit_cnt and miss_cnt are tied to 0.

Test Plan:
- Reset low mid-ALLOCATE (mem_req=1) -> mem_req, cpu_ready, cache_we_block go to 0 in the same cycle; state is IDLE after release.
- Read 0x0000_0040, cold cache (valid=0) -> ALLOCATE with mem_addr=0x40, mem_we=0. mem_ack after 3 cycles with block word1=0xDEADBEEF -> cache_we_block pulse, then COMPARE hit. Read 0x44 later -> cpu_rdata=0xDEADBEEF, 1-cycle hit latency.
- Write 0x48 data 0x12345678 on resident line -> cache_we_word one cycle, cpu_ready; a later read of 0x48 returns 0x12345678; cache_dirty=1.
- With dirty line at 0x40, read 0x1000 -> WRITEBACK with mem_addr=0x40, mem_we=1, mem_wdata=old block. After mem_ack -> ALLOCATE with mem_addr=0x1000, then cpu_ready.
- TIMEOUT=8, no mem_ack -> cpu_ready and cpu_err pulse on the 8th waiting cycle, no cache write. Repeat with mem_ack on that 8th cycle -> no cpu_err, refill proceeds.
- CACHE_CTRL_STATS_EN defined, sequence miss, hit, hit, miss -> hit_cnt=2, miss_cnt=2. Undefined -> both 0.
